gmii2xgmii: RTL and testbench



---
 rtl/gmii2xgmii_if.sv | 21 ++
 rtl/gmii2xgmii.sv | 232 +++++++++++++++++++++++
 tb/tb_gmii2xgmii.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gmii2xgmii_if.sv
// GMII byte-stream inputs and XGMII word outputs of the gmii2xgmii converter.
// slave is the converter side; master is the source/sink side.
interface gmii2xgmii_if;
  logic        gmii_valid;
  logic        gmii_en;
  logic        gmii_er;
  logic [7:0]  gmii_rxd;
  logic [7:0]  xgmii_txc;
  logic [63:0] xgmii_txd;
  logic        frame_drop;

  modport master (
    output gmii_valid, gmii_en, gmii_er, gmii_rxd,
    input  xgmii_txc, xgmii_txd, frame_drop
  );

  modport slave (
    input  gmii_valid, gmii_en, gmii_er, gmii_rxd,
    output xgmii_txc, xgmii_txd, frame_drop
  );
endinterface

// File: rtl/gmii2xgmii.sv
// Store-and-forward GMII byte stream to 64-bit XGMII word converter.
// Define GMII2XGMII_STATS_EN to add the stat_frames/stat_drops counters.
module gmii2xgmii #(
  parameter int DEPTH_LOG2 = 8,
  parameter int IFG_WORDS  = 1
) (
  input  logic        xgmii_clk,
  input  logic        sys_rst,
  gmii2xgmii_if.slave bus
`ifdef GMII2XGMII_STATS_EN
  ,
  output logic [31:0] stat_frames,
  output logic [31:0] stat_drops
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int AW    = DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  localparam logic [71:0] IDLE_WORD  = {8'hff, 64'h0707070707070707};
  localparam logic [71:0] START_WORD = {8'h01, 64'hd5555555555555fb};

  typedef enum logic [1:0] {W_HUNT, W_DATA, W_DROP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_SEND, R_IFG}  rstate_t;

  wstate_t wstate_reg, wstate_next;
  rstate_t rstate_reg, rstate_next;

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] commit_ptr_reg, commit_ptr_next;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW-1:0] fill;
  logic          full;

  logic [2:0]    lane_cnt_reg, lane_cnt_next;
  logic [63:0]   lane_data_reg, lane_data_next;
  logic [63:0]   lane_wr_data;
  logic [63:0]   term_txd;
  logic [7:0]    term_txc;

  logic          wr_en, rd_en, commit, abort;
  logic [71:0]   wr_word;
  logic [71:0]   rd_data_reg;
  logic          frame_drop_reg;

  logic [2:0]    ifg_cnt_reg, ifg_cnt_next;
  logic          rd_avail, is_term, ifg_last;
  logic [71:0]   out_reg, out_next;

  logic [71:0]   mem [0:DEPTH-1];

  assign fill = wr_ptr_reg - rd_ptr_reg;
  assign full = (fill == PW'(DEPTH));

  // Per-lane views: the data word being completed and the terminate word at lane k.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign lane_wr_data[gi*8 +: 8] = (3'(gi) == lane_cnt_reg) ? bus.gmii_rxd
                                                                : lane_data_reg[gi*8 +: 8];
      assign term_txd[gi*8 +: 8] = (3'(gi) <  lane_cnt_reg) ? lane_data_reg[gi*8 +: 8] :
                                   (3'(gi) == lane_cnt_reg) ? 8'hfd : 8'h07;
    end
  endgenerate

  assign term_txc = 8'hff << lane_cnt_reg;

  always_ff @(posedge xgmii_clk) begin
    if (wr_en) mem[wr_ptr_reg[AW-1:0]] <= wr_word;
  end

  always_ff @(posedge xgmii_clk) begin
    if (rd_en) rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      wstate_reg     <= W_HUNT;
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      lane_cnt_reg   <= '0;
      lane_data_reg  <= '0;
      frame_drop_reg <= 1'b0;
    end else begin
      wstate_reg     <= wstate_next;
      wr_ptr_reg     <= wr_ptr_next;
      commit_ptr_reg <= commit_ptr_next;
      lane_cnt_reg   <= lane_cnt_next;
      lane_data_reg  <= lane_data_next;
      frame_drop_reg <= abort;
    end
  end

  always_comb begin
    wstate_next = wstate_reg;
    case (wstate_reg)
      W_HUNT: if (bus.gmii_valid && bus.gmii_en) begin
        if (bus.gmii_er || (bus.gmii_rxd == 8'hd5 && full)) wstate_next = W_DROP;
        else if (bus.gmii_rxd == 8'hd5)                      wstate_next = W_DATA;
      end
      W_DATA: if (bus.gmii_valid) begin
        if (!bus.gmii_en)                                        wstate_next = W_HUNT;
        else if (bus.gmii_er || (lane_cnt_reg == 3'd7 && full)) wstate_next = W_DROP;
      end
      W_DROP: if (bus.gmii_valid && !bus.gmii_en) wstate_next = W_HUNT;
      default: wstate_next = W_HUNT;
    endcase
  end

  // An overflow on the terminate write returns straight to HUNT: the frame has
  // already ended, so waiting in DROP would swallow the next frame.
  always_comb begin
    wr_en           = 1'b0;
    wr_word         = START_WORD;
    commit          = 1'b0;
    abort           = 1'b0;
    wr_ptr_next     = wr_ptr_reg;
    commit_ptr_next = commit_ptr_reg;
    lane_cnt_next   = lane_cnt_reg;
    lane_data_next  = lane_data_reg;
    case (wstate_reg)
      W_HUNT: if (bus.gmii_valid && bus.gmii_en) begin
        if (bus.gmii_er) begin
          abort = 1'b1;
        end else if (bus.gmii_rxd == 8'hd5) begin
          if (full) abort = 1'b1;
          else begin
            wr_en         = 1'b1;
            wr_word       = START_WORD;
            lane_cnt_next = 3'd0;
          end
        end
      end
      W_DATA: if (bus.gmii_valid) begin
        if (bus.gmii_en && bus.gmii_er) begin
          abort = 1'b1;
        end else if (bus.gmii_en) begin
          lane_data_next = lane_wr_data;
          lane_cnt_next  = lane_cnt_reg + 3'd1;
          if (lane_cnt_reg == 3'd7) begin
            if (full) abort = 1'b1;
            else begin
              wr_en   = 1'b1;
              wr_word = {8'h00, lane_wr_data};
            end
          end
        end else begin
          if (full) abort = 1'b1;
          else begin
            wr_en   = 1'b1;
            wr_word = {term_txc, term_txd};
            commit  = 1'b1;
          end
        end
      end
      default: ;
    endcase
    if (wr_en)  wr_ptr_next     = wr_ptr_reg + PW'(1);
    if (commit) commit_ptr_next = wr_ptr_reg + PW'(1);
    if (abort)  wr_ptr_next     = commit_ptr_reg;
  end

  assign rd_avail = (rd_ptr_reg != commit_ptr_reg);
  assign is_term  = rd_data_reg[71];
  assign ifg_last = (ifg_cnt_reg == 3'(IFG_WORDS - 1));

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      rstate_reg  <= R_IDLE;
      rd_ptr_reg  <= '0;
      ifg_cnt_reg <= '0;
      out_reg     <= IDLE_WORD;
    end else begin
      rstate_reg  <= rstate_next;
      ifg_cnt_reg <= ifg_cnt_next;
      out_reg     <= out_next;
      if (rd_en) rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  always_comb begin
    rstate_next = rstate_reg;
    case (rstate_reg)
      R_IDLE: if (rd_avail) rstate_next = R_SEND;
      R_SEND: if (is_term)  rstate_next = R_IFG;
      R_IFG:  if (ifg_last) rstate_next = rd_avail ? R_SEND : R_IDLE;
      default: rstate_next = R_IDLE;
    endcase
  end

  // The last IFG cycle prefetches the next start word so the gap is exactly IFG_WORDS.
  always_comb begin
    rd_en        = 1'b0;
    out_next     = IDLE_WORD;
    ifg_cnt_next = 3'd0;
    case (rstate_reg)
      R_IDLE: rd_en = rd_avail;
      R_SEND: begin
        out_next = rd_data_reg;
        rd_en    = !is_term;
      end
      R_IFG: begin
        ifg_cnt_next = ifg_cnt_reg + 3'd1;
        rd_en        = ifg_last && rd_avail;
      end
      default: ;
    endcase
  end

  assign bus.xgmii_txc  = out_reg[71:64];
  assign bus.xgmii_txd  = out_reg[63:0];
  assign bus.frame_drop = frame_drop_reg;

`ifdef GMII2XGMII_STATS_EN
  logic [31:0] stat_frames_reg, stat_drops_reg;

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      stat_frames_reg <= '0;
      stat_drops_reg  <= '0;
    end else begin
      if (commit) stat_frames_reg <= stat_frames_reg + 32'd1;
      if (abort)  stat_drops_reg  <= stat_drops_reg + 32'd1;
    end
  end

  assign stat_frames = stat_frames_reg;
  assign stat_drops  = stat_drops_reg;
`endif

endmodule

// File: tb/tb_gmii2xgmii.sv
// Directed bench for gmii2xgmii (DEPTH_LOG2=4, IFG_WORDS=3); every output word
// is captured on the falling edge and checked against hand-computed words.
module tb_gmii2xgmii;
  localparam logic [71:0] IDLE_W  = {8'hff, 64'h0707070707070707};
  localparam logic [71:0] START_W = {8'h01, 64'hd5555555555555fb};
  localparam logic [71:0] TERM0_W = {8'hff, 64'h07070707070707fd};

  logic clk = 1'b0;
  logic sys_rst;
  always #5 clk = ~clk;

  gmii2xgmii_if bus();

`ifdef GMII2XGMII_STATS_EN
  logic [31:0] stat_frames, stat_drops;
`endif

  gmii2xgmii #(.DEPTH_LOG2(4), .IFG_WORDS(3)) dut (
    .xgmii_clk (clk),
    .sys_rst   (sys_rst),
    .bus       (bus)
`ifdef GMII2XGMII_STATS_EN
    ,
    .stat_frames (stat_frames),
    .stat_drops  (stat_drops)
`endif
  );

  logic [71:0] cap[$];
  int drop_total = 0;
  int tests = 0;
  int fails = 0;

  always @(negedge clk) begin
    cap.push_back({bus.xgmii_txc, bus.xgmii_txd});
    if (bus.frame_drop === 1'b1) drop_total++;
  end

  task automatic chk72(input string tag, input logic [71:0] got, input logic [71:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] cap_at(input int idx);
    if (idx >= 0 && idx < cap.size()) return cap[idx];
    return 'x;
  endfunction

  // Payload bytes are 0,1,2,... so data word i carries bytes 8i..8i+7, lane 0 lowest.
  function automatic logic [71:0] dword(input int base);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(base + j);
    return {8'h00, d};
  endfunction

  function automatic int find_start(input int from);
    for (int i = from; i < cap.size(); i++) if (cap[i] === START_W) return i;
    return -1;
  endfunction

  function automatic int count_starts(input int from);
    int n = 0;
    for (int i = from; i < cap.size(); i++) if (cap[i] === START_W) n++;
    return n;
  endfunction

  task automatic check_frame(input string tag, input int from, input int nbytes,
                             input logic [71:0] term, output int after);
    int s;
    s = find_start(from);
    tests++;
    assert (s >= 0) else begin
      fails++;
      $error("FAIL %s_start: observed none expected start word", tag);
    end
    if (s < 0) s = cap.size();
    for (int i = 0; i < nbytes / 8; i++)
      chk72($sformatf("%s_w%0d", tag, i), cap_at(s + 1 + i), dword(8 * i));
    chk72({tag, "_term"}, cap_at(s + 1 + nbytes / 8), term);
    after = s + 2 + nbytes / 8;
  endtask

  task automatic drive_byte(input logic en, input logic er, input logic [7:0] d, input int gap);
    @(negedge clk);
    bus.gmii_valid = 1'b1;
    bus.gmii_en    = en;
    bus.gmii_er    = er;
    bus.gmii_rxd   = d;
    // Gap cycles carry junk that must be ignored because valid is low.
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      bus.gmii_valid = 1'b0;
      bus.gmii_en    = 1'b1;
      bus.gmii_er    = 1'b1;
      bus.gmii_rxd   = 8'hd5;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.gmii_valid = 1'b0;
      bus.gmii_en    = 1'b0;
      bus.gmii_er    = 1'b0;
      bus.gmii_rxd   = 8'h00;
    end
  endtask

  task automatic send_frame(input int npre, input int nbytes, input int gap, input int er_at);
    for (int i = 0; i < npre; i++) drive_byte(1'b1, 1'b0, 8'h55, gap);
    drive_byte(1'b1, 1'b0, 8'hd5, gap);
    for (int i = 0; i < nbytes; i++) drive_byte(1'b1, (i == er_at), 8'(i), gap);
    drive_byte(1'b0, 1'b0, 8'h00, gap);
  endtask

  initial begin
    int base, d0, after, nidle, found;

    sys_rst        = 1'b1;
    bus.gmii_valid = 1'b0;
    bus.gmii_en    = 1'b0;
    bus.gmii_er    = 1'b0;
    bus.gmii_rxd   = 8'h00;
    repeat (3) @(negedge clk);
    chk72("reset_out", {bus.xgmii_txc, bus.xgmii_txd}, IDLE_W);
    chk_int("reset_drop", int'(bus.frame_drop), 0);
`ifdef GMII2XGMII_STATS_EN
    chk_int("reset_stat_frames", int'(stat_frames), 0);
    chk_int("reset_stat_drops", int'(stat_drops), 0);
`endif
    sys_rst = 1'b0;
    idle(2);
    chk72("post_reset_out", {bus.xgmii_txc, bus.xgmii_txd}, IDLE_W);

    // 64-byte frame, full-rate bytes
    base = cap.size();
    send_frame(7, 64, 0, -1);
    idle(30);
    check_frame("f64", base, 64, TERM0_W, after);
    chk72("f64_word0", cap_at(find_start(base) + 1), {8'h00, 64'h0706050403020100});
    chk72("f64_idle_after", cap_at(after), IDLE_W);

    // 61-byte frame: terminate at lane 5
    base = cap.size();
    send_frame(7, 61, 0, -1);
    idle(30);
    check_frame("f61", base, 61, {8'he0, 64'h0707fd3c3b3a3938}, after);

    // Sparse strobes and a short preamble normalise to the same output
    base = cap.size();
    send_frame(2, 64, 2, -1);
    idle(30);
    check_frame("slow", base, 64, TERM0_W, after);

    // Errored frame then a good one
    @(negedge clk); sys_rst = 1'b1;
    @(negedge clk); sys_rst = 1'b0;
    base = cap.size();
    d0   = drop_total;
    send_frame(7, 64, 0, 10);
    send_frame(7, 64, 0, -1);
    idle(30);
    chk_int("er_drop_pulses", drop_total - d0, 1);
    chk_int("er_start_count", count_starts(base), 1);
    check_frame("er_good", base, 64, TERM0_W, after);
`ifdef GMII2XGMII_STATS_EN
    chk_int("er_stat_frames", int'(stat_frames), 1);
    chk_int("er_stat_drops", int'(stat_drops), 1);
`endif

    // Oversize frame overflows the 16-word buffer; the next frame must follow clean
    base = cap.size();
    d0   = drop_total;
    send_frame(7, 200, 0, -1);
    send_frame(7, 40, 0, -1);
    idle(30);
    chk_int("ovf_drop_pulses", drop_total - d0, 1);
    chk_int("ovf_start_count", count_starts(base), 1);
    check_frame("ovf_next", base, 40, TERM0_W, after);

    // Back-to-back: short second frame commits while the first is still going out
    base = cap.size();
    send_frame(7, 64, 0, -1);
    send_frame(0, 8, 0, -1);
    idle(30);
    check_frame("b2b_a", base, 64, TERM0_W, after);
    nidle = 0;
    while (cap_at(after + nidle) === IDLE_W) nidle++;
    chk_int("b2b_ifg_words", nidle, 3);
    check_frame("b2b_b", after, 8, TERM0_W, after);

    // Reset while a frame is leaving: idle on the very next word, nothing resumes
    send_frame(7, 64, 0, -1);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if ({bus.xgmii_txc, bus.xgmii_txd} === START_W) found = 1;
    end
    chk_int("rst_mid_seen_start", found, 1);
    sys_rst = 1'b1;
    @(negedge clk);
    chk72("rst_mid_out", {bus.xgmii_txc, bus.xgmii_txd}, IDLE_W);
    sys_rst = 1'b0;
    base = cap.size();
    idle(30);
    chk_int("rst_mid_no_resume", count_starts(base), 0);
`ifdef GMII2XGMII_STATS_EN
    chk_int("rst_mid_stat_frames", int'(stat_frames), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
